// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: the chunked-subtractor FSM state and sizing helpers.
package arith_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } sub_state_t;

    function automatic int calc_nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-chunk configuration still needs a 1-bit counter.
    function automatic int calc_cnt_w(input int nchunk);
        return (nchunk <= 1) ? 1 : $clog2(nchunk);
    endfunction

endpackage

// File: rtl/sub_chunk_slice.sv
// Combinational CHUNK-bit subtract with borrow in/out.
module sub_chunk_slice #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             bi,
    output logic [CHUNK-1:0] d,
    output logic             bo
);

    // The wrap into bit CHUNK of the widened difference is exactly the borrow out.
    assign {bo, d} = {1'b0, a} - {1'b0, b} - {{CHUNK{1'b0}}, bi};

endmodule

// File: rtl/sub_chunked.sv
// Multi-cycle x - y - bin, CHUNK bits per clock, LS chunk first, registered borrow.
module sub_chunked
    import arith_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int CHUNK  = 8,
    parameter int SWIDTH = WIDTH + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              bin,
    input  logic [WIDTH-1:0]  x,
    input  logic [WIDTH-1:0]  y,
    output logic              busy,
    output logic              done,
    output logic [SWIDTH-1:0] df,
    output logic              df_zero,
    output logic              df_neg
);

    localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
    localparam int CW     = calc_cnt_w(NCHUNK);

    sub_state_t       state, state_nx;
    logic [WIDTH-1:0] xr, yr, wr, wr_nx;
    logic [CW-1:0]    k;
    logic             br;
    logic             accept, last;
    logic [CHUNK-1:0] d;
    logic             bo;

    sub_chunk_slice #(.CHUNK(CHUNK)) u_slice (
        .a  (xr[k*CHUNK +: CHUNK]),
        .b  (yr[k*CHUNK +: CHUNK]),
        .bi (br),
        .d  (d),
        .bo (bo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        last     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                if (k == CW'(NCHUNK - 1)) begin
                    last     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Working register with the current chunk merged in; the final chunk goes straight to df.
    always_comb begin
        wr_nx = wr;
        wr_nx[k*CHUNK +: CHUNK] = d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xr      <= '0;
            yr      <= '0;
            wr      <= '0;
            k       <= '0;
            br      <= 1'b0;
            done    <= 1'b0;
            df      <= '0;
            df_zero <= 1'b0;
            df_neg  <= 1'b0;
        end else begin
            done <= last;
            if (accept) begin
                xr <= x;
                yr <= y;
                br <= bin;
                k  <= '0;
            end else if (state == BUSY) begin
                wr <= wr_nx;
                br <= bo;
                k  <= last ? '0 : k + 1'b1;
                if (last) begin
                    df      <= SWIDTH'({bo, wr_nx});
                    df_zero <= ({bo, wr_nx} == '0);
                    df_neg  <= bo;
                end
            end
        end
    end

    assign busy = (state == BUSY);

endmodule
